key_stream_serializer: RTL and testbench
========================================

KEY_STREAM_SERIALIZER -- requirements
Module: key_stream_serializer

Interface
REQ-001 Parameter: NUM_WORDS, default 16; number of 32-bit words per 512-bit key block.
REQ-002 Parameter: WORD_SIZE, default 32; output word width in bits, with NUM_WORDS*WORD_SIZE = 512.
REQ-003 clock  input  1  clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 key_in  input  512  key block from the generator; word i = key_in[32i+31:32i].
REQ-006 key_valid  input  1  key_in holds a finished block.
REQ-007 key_done  output  1  serializer is free; the generator may start the next block.
REQ-008 pt_data  input  32  plaintext word.
REQ-009 pt_valid  input  1  pt_data is valid.
REQ-010 pt_ready  output  1  serializer accepts pt_data this cycle.
REQ-011 ct_data  output  32  registered output word.
REQ-012 ct_valid  output  1  ct_data is valid.
REQ-013 ct_ready  input  1  downstream accepts ct_data this cycle.
REQ-014 ct_last  output  1  ct_data is word NUM_WORDS-1 of the block.

Function
REQ-015 The block SHALL have three states: IDLE, STREAM and DRAIN; a 512-bit key register; and a 5-bit word index idx.
REQ-016 key_done SHALL be 1 in IDLE and DRAIN and 0 in STREAM.
REQ-017 In IDLE with key_valid=1, the block SHALL capture key_in, clear idx and enter STREAM on the same edge (latency 1 cycle).
REQ-018 pt_ready SHALL be 1 only when all of the following hold: state is STREAM, idx<NUM_WORDS, and (ct_valid=0 or ct_ready=1).
REQ-019 On pt_valid&&pt_ready:
- ct_data SHALL take pt_data XOR key word idx;
- ct_valid SHALL be set to 1;
- ct_last SHALL be set to (idx==NUM_WORDS-1);
- idx SHALL increment.
REQ-020 On ct_valid&&ct_ready without a new accept, ct_valid SHALL clear to 0 and ct_data SHALL hold its value.
REQ-021 Sustained throughput SHALL be one word per cycle when pt_valid and ct_ready are both held at 1.
REQ-022 Once idx==NUM_WORDS, pt_ready SHALL stay 0 and no further input SHALL be consumed.
REQ-023 On ct_valid&&ct_ready&&ct_last, the block SHALL clear ct_valid and ct_last and enter DRAIN.
REQ-024 In DRAIN, the block SHALL return to IDLE on the first cycle with key_valid=0; a stale key_valid SHALL never start a second pass over the same key.
REQ-025 ct_data and ct_valid SHALL remain stable while ct_valid=1 and ct_ready=0 (backpressure).
REQ-026 Changes on key_in or key_valid during STREAM SHALL be ignored.

Reset
REQ-027 Asserting reset_n=0 SHALL immediately force all of the following:
- state DRAIN, idx 0;
- key register 0;
- ct_data 0, ct_valid 0, ct_last 0;
- pt_ready 0, key_done 1.
REQ-028 A reset during STREAM SHALL discard the block in progress; a stale key_valid still high after reset SHALL therefore not be serialized.

Configuration
REQ-029 Macro KSER_XOR_EN defined: XOR cipher mode per REQ-018 to REQ-019.
REQ-030 Macro KSER_XOR_EN undefined:
- pt_ready SHALL be held at 0 and pt_data ignored;
- a raw key word SHALL be emitted whenever the REQ-018 conditions hold;
- ct_data SHALL equal key word idx, with the same ct_last and DRAIN behaviour.

Verification
REQ-031 Reset, then key_valid=0 for 1 cycle -> key_done=1, state IDLE, ct_valid=0.
REQ-032 Key word i = 0x01010101*i, pt_data = 0xFFFFFFFF for 16 words, ct_ready=1 -> ct_data[i] = ~(0x01010101*i), one per cycle; ct_last=1 only on word 15; key_done=0 for exactly 17 cycles.
REQ-033 ct_ready=0 for 5 cycles after word 3 -> ct_data holds word 3 and pt_ready=0 throughout; word 4 is emitted on release, with no loss or duplication.
REQ-034 key_valid held at 1 after block completion -> block stays in DRAIN with key_done=1 and ct_valid=0; it reaches IDLE one cycle after key_valid drops.
REQ-035 reset_n pulsed low after word 7 -> ct_valid=0 and key_done=1 immediately; no further words are emitted until key_valid goes 0 then 1.
REQ-036 KSER_XOR_EN undefined, key word i = 0xA5000000+i -> 16 words 0xA5000000 to 0xA500000F are emitted; pt_ready=0 throughout.

Source files
------------

// File: rtl/key_stream_serializer.sv
// Serializes a 512-bit key block into 32-bit words over a valid/ready stream.
// Build option KSER_XOR_EN: XOR each plaintext word with the key word; otherwise emit raw key words.
module key_stream_serializer #(
    parameter int unsigned NUM_WORDS = 16,
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_WORDS*WORD_SIZE-1:0] key_in,
    input  logic                           key_valid,
    output logic                           key_done,
    input  logic [WORD_SIZE-1:0]           pt_data,
    input  logic                           pt_valid,
    output logic                           pt_ready,
    output logic [WORD_SIZE-1:0]           ct_data,
    output logic                           ct_valid,
    input  logic                           ct_ready,
    output logic                           ct_last
);

    localparam int unsigned IDX_W = 5;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain
    } state_e;

    state_e                         state_q, state_d;
    logic [NUM_WORDS*WORD_SIZE-1:0] key_q, key_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [WORD_SIZE-1:0]           ct_data_q, ct_data_d;
    logic                           ct_valid_q, ct_valid_d;
    logic                           ct_last_q, ct_last_d;

    logic                           room;
    logic                           accept;
    logic [WORD_SIZE-1:0]           key_word;
    logic [WORD_SIZE-1:0]           out_word;

    always_comb begin
        key_word = '0;
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                key_word = key_q[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // A slot is free when streaming, words remain, and the output register can be refilled.
    assign room = (state_q == StStream) && (idx_q < IDX_W'(NUM_WORDS)) &&
                  (!ct_valid_q || ct_ready);

`ifdef KSER_XOR_EN
    assign pt_ready = room;
    assign accept   = pt_valid && room;
    assign out_word = key_word ^ pt_data;
`else
    logic unused_pt;
    assign unused_pt = ^{pt_data, pt_valid};
    assign pt_ready  = 1'b0;
    assign accept    = room;
    assign out_word  = key_word;
`endif

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        idx_d      = idx_q;
        ct_data_d  = ct_data_q;
        ct_valid_d = ct_valid_q;
        ct_last_d  = ct_last_q;
        case (state_q)
            StIdle: begin
                if (key_valid) begin
                    key_d   = key_in;
                    idx_d   = '0;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (accept) begin
                    ct_data_d  = out_word;
                    ct_valid_d = 1'b1;
                    ct_last_d  = (idx_q == IDX_W'(NUM_WORDS - 1));
                    idx_d      = idx_q + 1'b1;
                end else if (ct_valid_q && ct_ready) begin
                    ct_valid_d = 1'b0;
                    ct_last_d  = 1'b0;
                    if (ct_last_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Wait for key_valid to drop so a stale request cannot replay the same key.
                if (!key_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StDrain;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StDrain;
            key_q      <= '0;
            idx_q      <= '0;
            ct_data_q  <= '0;
            ct_valid_q <= 1'b0;
            ct_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            idx_q      <= idx_d;
            ct_data_q  <= ct_data_d;
            ct_valid_q <= ct_valid_d;
            ct_last_q  <= ct_last_d;
        end
    end

    assign key_done = (state_q != StStream);
    assign ct_data  = ct_data_q;
    assign ct_valid = ct_valid_q;
    assign ct_last  = ct_last_q;

endmodule

// File: tb/tb_key_stream_serializer.sv
// Self-checking bench for key_stream_serializer; the reference is an ordered list of key words
// (XORed with the accepted plaintext words when KSER_XOR_EN is defined).
module tb_key_stream_serializer;

    localparam int N = 16;
    localparam int W = 32;
`ifdef KSER_XOR_EN
    localparam bit XorMode = 1'b1;
`else
    localparam bit XorMode = 1'b0;
`endif

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [N*W-1:0] key_in = '0;
    logic           key_valid = 1'b0;
    logic           key_done;
    logic [W-1:0]   pt_data = '0;
    logic           pt_valid = 1'b0;
    logic           pt_ready;
    logic [W-1:0]   ct_data;
    logic           ct_valid;
    logic           ct_ready = 1'b0;
    logic           ct_last;

    int             vectors = 0;
    int             miscompares = 0;
    logic [W-1:0]   key_words [N];

    key_stream_serializer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_done  (key_done),
        .pt_data   (pt_data),
        .pt_valid  (pt_valid),
        .pt_ready  (pt_ready),
        .ct_data   (ct_data),
        .ct_valid  (ct_valid),
        .ct_ready  (ct_ready),
        .ct_last   (ct_last)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_key_done"}, key_done, 1);
        check({tag, "_ct_valid"}, ct_valid, 0);
        check({tag, "_ct_last"}, ct_last, 0);
        check({tag, "_pt_ready"}, pt_ready, 0);
    endtask

    // Called at a negedge with the DUT in IDLE. Loads key_words, then streams until
    // stop_at words have been handed downstream.
    task automatic run_block(input int rdy_pct, input int pv_pct, input bit pt_ones,
                             input int stall_at, input int stop_at, input int exp_busy);
        logic [W-1:0] pt_q[$];
        logic [W-1:0] held;
        logic [W-1:0] exp_word;
        int k = 0;
        int busy = 0;
        int cyc = 0;
        int stall_left = 0;
        bit stalled = 1'b0;
        bit hold = 1'b0;
        held = '0;
        for (int i = 0; i < N; i++) key_in[i*W +: W] = key_words[i];
        key_valid = 1'b1;
        @(negedge clock);
        while (k < stop_at && cyc < 2000) begin
            cyc++;
            // Key inputs are scrambled mid-stream; they must have no effect.
            key_valid = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) key_in[i*W +: W] = $urandom();
            if (stall_left == 0 && !stalled && ct_valid && k == stall_at) begin
                stall_left = 5;
                stalled = 1'b1;
            end
            if (stall_left > 0) begin
                ct_ready = 1'b0;
                stall_left--;
            end else begin
                ct_ready = ($urandom_range(1, 100) <= rdy_pct);
            end
            pt_valid = ($urandom_range(1, 100) <= pv_pct);
            pt_data  = pt_ones ? 32'hFFFF_FFFF : $urandom();
            #1;
            check("key_done_stream", key_done, 0);
            busy++;
            if (!XorMode) check("pt_ready_raw", pt_ready, 0);
            if (ct_valid && !ct_ready) check("pt_ready_backpressure", pt_ready, 0);
            if (pt_ready) check("pt_ready_words_left", (pt_q.size() < N), 1);
            if (hold) begin
                check("hold_valid", ct_valid, 1);
                check("hold_data", ct_data, held);
            end
            if (pt_valid && pt_ready) pt_q.push_back(pt_data);
            if (ct_valid && ct_ready) begin
                exp_word = XorMode ? (key_words[k] ^ pt_q[k]) : key_words[k];
                check($sformatf("ct_data_w%0d", k), ct_data, exp_word);
                check($sformatf("ct_last_w%0d", k), ct_last, (k == N - 1));
                k++;
            end
            hold = ct_valid && !ct_ready;
            held = ct_data;
            @(negedge clock);
        end
        check("words_emitted", k, stop_at);
        if (exp_busy >= 0) check("busy_cycles", busy, exp_busy);
        if (stop_at == N) check_idle_outputs("drain");
    endtask

    task automatic go_idle();
        key_valid = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        // Reset values, then one cycle with key_valid low to reach IDLE.
        #1;
        check_idle_outputs("reset");
        check("reset_ct_data", ct_data, 0);
        @(negedge clock);
        reset_n = 1'b1;
        go_idle();
        check_idle_outputs("idle");

        // Full throughput, key word i = 0x01010101*i, plaintext all ones.
        for (int i = 0; i < N; i++) key_words[i] = 32'h0101_0101 * i;
        run_block(100, 100, 1'b1, -1, N, 17);

        // Stale key_valid must hold the block in DRAIN.
        key_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("drain_key_done", key_done, 1);
            check("drain_ct_valid", ct_valid, 0);
        end
        go_idle();

        // Five-cycle stall on word 3.
        for (int i = 0; i < N; i++) key_words[i] = $urandom();
        run_block(100, 100, 1'b0, 3, N, 22);
        go_idle();

        // Random backpressure and plaintext gaps.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < N; i++) key_words[i] = $urandom();
            run_block(60, 70, 1'b0, -1, N, -1);
            go_idle();
        end

        // Reset after word 7 with key_valid held high.
        for (int i = 0; i < N; i++) key_words[i] = $urandom();
        run_block(100, 100, 1'b0, -1, 8, -1);
        key_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        check("abort_ct_data", ct_data, 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check("abort_stale_key_done", key_done, 1);
            check("abort_stale_ct_valid", ct_valid, 0);
        end
        go_idle();

        // Raw-key pattern 0xA5000000 + i.
        for (int i = 0; i < N; i++) key_words[i] = 32'hA500_0000 + i;
        run_block(100, 100, 1'b0, -1, N, 17);
        go_idle();
        check_idle_outputs("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
